video_timing_pattern_gen: RTL and testbench
===========================================

Name: video_timing_pattern_gen

Overview:
- Parametrised video timing generator for the display path. Default parameters give 1280x720@60 on a 74.25 MHz i_pixclk.
- Emits pixel request coordinates to a downstream pixel source, such as the game frame renderer.
- Accepts returned pixel data after a fixed source latency and drives sync, DE and RGB outputs that are phase-aligned to each other.
- Adds selectable built-in test patterns, programmable sync polarity, frame/line strobes and a frame counter.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, horizontal sync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- CNT_W, 12, width of coordinate counters
- SRC_LAT, 2, pixel source latency in clocks from o_cnt_x/o_cnt_y to i_pix_*, range 0..7

Ports:
- i_pixclk  in  1  pixel clock
- i_reset_n  in  1  synchronous active-low reset
- i_enable  in  1  run timing; low holds the counters at origin
- i_mode  in  2  0 external, 1 colour bars, 2 checkerboard, 3 solid fill
- i_fill_rgb  in  24  solid colour {b,g,r} for mode 3
- i_pix_rgb  in  24  external pixel {b,g,r}, valid SRC_LAT clocks after request
- i_pix_dav  in  1  external pixel valid; low means draw black
- o_cnt_x  out  CNT_W  horizontal request coordinate
- o_cnt_y  out  CNT_W  vertical request coordinate
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  data enable
- o_rgb  out  24  output pixel {b,g,r}
- o_frame_start  out  1  one-clock pulse with output pixel (0,0)
- o_line_start  out  1  one-clock pulse with output pixel x=0 of each line, including blank lines
- o_frame_cnt  out  16  completed-frame counter

Behaviour:
- Clock i_pixclk; reset i_reset_n, synchronous, active-low. All state updates on the rising edge of i_pixclk.
- Reset values:
  - o_cnt_x = 0, o_cnt_y = 0.
  - o_hsync = ~HS_POL, o_vsync = ~VS_POL.
  - o_de, o_rgb, o_frame_start, o_line_start = 0.
  - o_frame_cnt = 0; latched mode = 0.
  - Pipeline valid bits cleared.
- Totals: HT = H_ACTIVE+H_FP+H_SYNC+H_BP; VT = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters:
  - x increments 0..HT-1, then wraps to 0 and advances y.
  - y runs 0..VT-1 and wraps to 0.
  - o_cnt_x/o_cnt_y are the counter registers themselves.
- Raw timing per counter state:
  - de = x<H_ACTIVE && y<V_ACTIVE.
  - hs asserted when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; vs is whole-line granular, changing at x=0.
- Alignment:
  - Raw de/hs/vs/strobes pass through a SRC_LAT-deep delay line plus one output register stage.
  - Latency L = SRC_LAT+1 clocks from counter state to output, identical in all modes.
- Mode latch: i_mode is sampled only when the counter is at (0,0). A mid-frame change takes effect at the next frame.
- Pixel select, in the output register stage:
  - If delayed de = 0: o_rgb = 0.
  - Mode 0: o_rgb = i_pix_dav ? i_pix_rgb : 0.
  - Mode 1 (colour bars):
    - 8 vertical bars, each H_ACTIVE/8 pixels wide, computed from the delayed x.
    - Order: white FFFFFF, yellow 00FFFF, cyan FFFF00, green 00FF00, magenta FF00FF, red 0000FF, blue FF0000, black 000000 ({b,g,r} hex).
    - Bar boundaries use comparison against constant multiples; no divider.
  - Mode 2 (checkerboard): x[5]^y[5] on delayed coordinates; 1 = FFFFFF, 0 = 000000.
  - Mode 3 (solid fill): i_fill_rgb, sampled at the output register.
- i_enable:
  - When low, counters load (0,0) and hold, and zeros enter the delay line.
  - Outputs go inactive (syncs deasserted, de=0, rgb=0) L clocks later.
  - On re-enable, the frame starts from (0,0) and the mode is latched at that point.
- o_frame_cnt:
  - Increments by 1 on the clock the counter wraps from (HT-1,VT-1) to (0,0) while enabled.
  - 16-bit wrap: FFFF -> 0000.
  - Not incremented when i_enable is forced low mid-frame.
- Reset mid-frame: all outputs return to their reset values on the next edge, and the delay line is flushed.
- Parameter constraints: H_ACTIVE divisible by 8; HT and VT must fit in CNT_W bits. Violations are out of scope.

Test Plan:
- Reset held 5 clocks with i_enable=1:
  - o_hsync=1, o_vsync=1, o_de=0, o_rgb=0, o_frame_cnt=0.
  - After release, first o_de=1 appears exactly L=3 clocks after o_cnt_x=0, o_cnt_y=0.
- Defaults, run 2 frames:
  - o_hsync low for exactly 40 clocks per line, starting 3 clocks after o_cnt_x=1390.
  - o_vsync low for 5x1650 clocks.
  - Frame period 1,237,500 clocks; o_frame_cnt reaches 2.
- Mode 1, line 0:
  - Output pixel x=159 is FFFFFF and x=160 is 00FFFF.
  - x=1279 is 000000.
  - o_rgb=0 throughout blanking.
- Mode changed 0->2 at o_cnt_y=100:
  - Current frame stays external.
  - Next frame: output pixel (32,0)=FFFFFF, (32,32)=000000.
- Small parameters H 8/2/2/2, V 4/1/1/1, SRC_LAT=0, HS_POL=1:
  - HT=14, VT=7; frame = 98 clocks.
  - hsync high at output for x 10..11.
  - o_line_start once every 14 clocks.
- i_enable dropped mid-line, held 20 clocks, then raised:
  - Outputs inactive from L clocks after the drop.
  - o_frame_cnt unchanged.
  - o_frame_start pulses L clocks after re-enable.

Source files
------------

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with pixel-source request coordinates, latency-matched
// sync/DE/RGB outputs, built-in test patterns, line/frame strobes and a frame counter.
module video_timing_pattern_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned SRC_LAT  = 2
) (
    input  logic             i_pixclk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [23:0]      i_fill_rgb,
    input  logic [23:0]      i_pix_rgb,
    input  logic             i_pix_dav,
    output logic [CNT_W-1:0] o_cnt_x,
    output logic [CNT_W-1:0] o_cnt_y,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [23:0]      o_rgb,
    output logic             o_frame_start,
    output logic             o_line_start,
    output logic [15:0]      o_frame_cnt
);

    localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;

    // Per-pixel timing record carried through the source-latency delay line
    typedef struct packed {
        logic             de;
        logic             hs;
        logic             vs;
        logic             fs;
        logic             ls;
        logic [1:0]       mode;
        logic             y5;
        logic [CNT_W-1:0] x;
    } tap_t;

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]       mode_q, mode_d, mode_eff;
    logic [15:0]      fcnt_q, fcnt_d;
    logic             at_origin, end_x, end_y;
    tap_t             raw, dly_out;

    logic             hs_q, vs_q, de_q, fs_q, ls_q;
    logic [23:0]      rgb_q, rgb_d;

    // Counter advance, frame counting and frame-boundary mode capture
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        fcnt_d    = fcnt_q;
        at_origin = (x_q == '0) && (y_q == '0);
        end_x     = (x_q == CNT_W'(HT - 1));
        end_y     = (y_q == CNT_W'(VT - 1));
        mode_eff  = at_origin ? i_mode : mode_q;
        mode_d    = mode_eff;
        if (!i_enable) begin
            x_d = '0;
            y_d = '0;
        end else if (end_x) begin
            x_d = '0;
            if (end_y) begin
                y_d    = '0;
                fcnt_d = fcnt_q + 16'd1;
            end else begin
                y_d = y_q + CNT_W'(1);
            end
        end else begin
            x_d = x_q + CNT_W'(1);
        end
    end

    // Raw timing decoded from the current counter state; zeros while disabled
    always_comb begin
        raw = '0;
        if (i_enable) begin
            raw.de   = (x_q < CNT_W'(H_ACTIVE)) && (y_q < CNT_W'(V_ACTIVE));
            raw.hs   = (x_q >= CNT_W'(HS_START)) && (x_q < CNT_W'(HS_END));
            raw.vs   = (y_q >= CNT_W'(VS_START)) && (y_q < CNT_W'(VS_END));
            raw.fs   = at_origin;
            raw.ls   = (x_q == '0);
            raw.mode = mode_eff;
            raw.y5   = y_q[5];
            raw.x    = x_q;
        end
    end

    generate
        if (SRC_LAT == 0) begin : g_nodly
            assign dly_out = raw;
        end else begin : g_dly
            tap_t pipe_q [SRC_LAT];
            always_ff @(posedge i_pixclk) begin
                if (!i_reset_n) begin
                    for (int unsigned i = 0; i < SRC_LAT; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= raw;
                    for (int unsigned i = 1; i < SRC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign dly_out = pipe_q[SRC_LAT-1];
        end
    endgenerate

    function automatic logic [23:0] bar_rgb(input logic [CNT_W-1:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x >= CNT_W'(k * BAR_W)) idx = 3'(k);
        end
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'h00FFFF;
            3'd2:    bar_rgb = 24'hFFFF00;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'h0000FF;
            3'd6:    bar_rgb = 24'hFF0000;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction

    // Pixel select for the delayed pixel; external data arrives aligned with it
    always_comb begin
        rgb_d = '0;
        if (dly_out.de) begin
            case (dly_out.mode)
                2'd0:    rgb_d = i_pix_dav ? i_pix_rgb : 24'h000000;
                2'd1:    rgb_d = bar_rgb(dly_out.x);
                2'd2:    rgb_d = (dly_out.x[5] ^ dly_out.y5) ? 24'hFFFFFF : 24'h000000;
                default: rgb_d = i_fill_rgb;
            endcase
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= 2'd0;
            fcnt_q <= 16'd0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            ls_q   <= 1'b0;
            rgb_q  <= 24'h000000;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            mode_q <= mode_d;
            fcnt_q <= fcnt_d;
            hs_q   <= dly_out.hs ? HS_POL : ~HS_POL;
            vs_q   <= dly_out.vs ? VS_POL : ~VS_POL;
            de_q   <= dly_out.de;
            fs_q   <= dly_out.fs;
            ls_q   <= dly_out.ls;
            rgb_q  <= rgb_d;
        end
    end

    assign o_cnt_x       = x_q;
    assign o_cnt_y       = y_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_de          = de_q;
    assign o_rgb         = rgb_q;
    assign o_frame_start = fs_q;
    assign o_line_start  = ls_q;
    assign o_frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Randomised bench for video_timing_pattern_gen on a reduced raster, compared every
// clock against a raster-position model built from frame arithmetic.
module tb_video_timing_pattern_gen;

    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HSW = 6;
    localparam int HBP = 6;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VSW = 3;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;
    localparam int LAT = 2;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n, en, dav;
    logic [1:0]  mode;
    logic [23:0] fill, pix;
    logic [11:0] cnt_x, cnt_y;
    logic        hsync, vsync, de, fs, ls;
    logic [23:0] rgb;
    logic [15:0] fcnt;

    always #5 clk = ~clk;

    video_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .CNT_W(12), .SRC_LAT(LAT)
    ) dut (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
        .i_fill_rgb(fill), .i_pix_rgb(pix), .i_pix_dav(dav),
        .o_cnt_x(cnt_x), .o_cnt_y(cnt_y), .o_hsync(hsync), .o_vsync(vsync),
        .o_de(de), .o_rgb(rgb), .o_frame_start(fs), .o_line_start(ls),
        .o_frame_cnt(fcnt)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          c     = 16;
    int          pos   = 0;
    logic [15:0] fc    = 16'h0;
    logic [1:0]  mlat  = 2'b0;

    // Per-clock history of inputs and raster position, indexed by clock number mod 16
    bit          h_rst  [16];
    bit          h_en   [16];
    int          h_pos  [16];
    logic [1:0]  h_mode [16];
    logic [23:0] h_pix  [16];
    logic [23:0] h_fill [16];
    bit          h_dav  [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (clock %0d)", tag, obs, exp, c);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int x, input int y, input logic [1:0] m,
                                            input logic [23:0] p, input bit v, input logic [23:0] f);
        case (m)
            2'd0: return v ? p : 24'h0;
            2'd1: begin
                case (x / (HA / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'h00FFFF;
                    2: return 24'hFFFF00;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'h0000FF;
                    6: return 24'hFF0000;
                    default: return 24'h000000;
                endcase
            end
            2'd2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: return f;
        endcase
    endfunction

    // Record this clock's inputs, advance the model across the edge, then compare
    task automatic tick();
        int k, j, x, y;
        logic [1:0] meff;
        bit any_rst, e_de, e_hs, e_vs, e_fs, e_ls;
        logic [23:0] e_rgb;
        k    = c % 16;
        meff = (pos == 0) ? mode : mlat;
        h_rst[k] = rst_n; h_en[k] = en; h_pos[k] = pos; h_mode[k] = meff;
        h_pix[k] = pix;   h_dav[k] = dav; h_fill[k] = fill;
        if (!rst_n) begin
            pos = 0; fc = 16'h0; mlat = 2'b0;
        end else begin
            mlat = meff;
            if (!en) pos = 0;
            else begin
                if (pos == FT - 1) fc = fc + 16'd1;
                pos = (pos + 1) % FT;
            end
        end
        @(negedge clk);
        check("cnt_x", 32'(cnt_x), 32'(pos % HT));
        check("cnt_y", 32'(cnt_y), 32'(pos / HT));
        check("frame_cnt", 32'(fcnt), 32'(fc));
        any_rst = 1'b0;
        for (int i = 0; i <= LAT; i++) if (!h_rst[(c - i) % 16]) any_rst = 1'b1;
        j = (c - LAT) % 16;
        e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_ls = 0; e_rgb = 24'h0;
        if (!any_rst && h_en[j]) begin
            x     = h_pos[j] % HT;
            y     = h_pos[j] / HT;
            e_de  = (x < HA) && (y < VA);
            e_hs  = (x >= HA + HFP) && (x < HA + HFP + HSW);
            e_vs  = (y >= VA + VFP) && (y < VA + VFP + VSW);
            e_fs  = (h_pos[j] == 0);
            e_ls  = (x == 0);
            e_rgb = e_de ? exp_rgb(x, y, h_mode[j], h_pix[k], h_dav[k], h_fill[k]) : 24'h0;
        end
        check("hsync", 32'(hsync), 32'(e_hs ? HSP : !HSP));
        check("vsync", 32'(vsync), 32'(e_vs ? VSP : !VSP));
        check("de", 32'(de), 32'(e_de));
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("frame_start", 32'(fs), 32'(e_fs));
        check("line_start", 32'(ls), 32'(e_ls));
        c++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            pix  = 24'($urandom);
            dav  = ($urandom_range(0, 3) != 0);
            fill = 24'($urandom);
            tick();
        end
    endtask

    task automatic run_until_line(input int line);
        int guard;
        guard = 0;
        while ((pos / HT) != line && guard < 2 * FT) begin
            run(1);
            guard++;
        end
        check("wait_line", 32'(pos / HT), 32'(line));
    endtask

    initial begin
        logic [15:0] fc_saved;
        for (int i = 0; i < 16; i++) begin
            h_rst[i] = 1'b0; h_en[i] = 1'b0; h_pos[i] = 0; h_mode[i] = 2'b0;
            h_pix[i] = 24'h0; h_fill[i] = 24'h0; h_dav[i] = 1'b0;
        end
        rst_n = 1'b0; en = 1'b1; mode = 2'd1; fill = 24'h0; pix = 24'h0; dav = 1'b0;

        run(5);
        check("rst_hsync_level", 32'(hsync), 32'd1);
        check("rst_vsync_level", 32'(vsync), 32'd0);
        check("rst_fcnt", 32'(fcnt), 32'd0);
        rst_n = 1'b1;

        // Colour bars for a full frame
        run(FT + 200);

        // External source, switched to checkerboard mid-frame
        mode = 2'd0;
        run(FT);
        run_until_line(20);
        mode = 2'd2;
        run(2 * FT);

        // Solid fill
        mode = 2'd3;
        run(FT);

        // Enable dropped mid-line for 20 clocks
        run_until_line(10);
        while ((pos % HT) != 30) run(1);
        fc_saved = fc;
        en = 1'b0;
        run(20);
        check("fcnt_hold_on_disable", 32'(fcnt), 32'(fc_saved));
        en = 1'b1;
        run(LAT + 1);
        check("frame_start_after_enable", 32'(fs), 32'd1);
        run(FT + 100);

        // Random mode changes with a mid-frame reset
        for (int s = 0; s < 8; s++) begin
            mode = 2'($urandom_range(0, 3));
            run($urandom_range(200, 2000));
            if (s == 4) begin
                rst_n = 1'b0;
                run(3);
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
